csa_mult_seq: RTL and testbench

- Parametrised, iterative unsigned multiplier-accumulator built on a carry-save accumulator.
- Each cycle it adds STEP partial products into redundant sum/carry vectors. One final carry-propagate add then resolves the product.
- It is the next generation of the fixed-width combinational CSA stage. It adds configurable width, a configurable number of partial products per cycle, an accumulate mode, and a valid/ready handshake.
- It sits between the operand registers and the result path of the multiplier datapath.

---
 rtl/csa_mult_seq.sv | 100 ++++++++++
 tb/tb_csa_mult_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_mult_seq.sv
// Iterative unsigned multiply-accumulate: STEP partial products per cycle into carry-save sum/carry,
// then one carry-propagate add. Result valid N+1 edges after accept; holds in DONE until out_ready.
module csa_mult_seq #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_acc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int N  = WIDTH / STEP;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCUM   = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state;
  logic [PW-1:0]    sum_q, carry_q, mcand_q, res_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;

  logic [PW-1:0]    csa_sum, csa_carry, pp, tsum, maj;

  // Chain of 3:2 compressors, one per partial product; carries past bit PW-1 fall off the shift.
  always_comb begin
    csa_sum   = sum_q;
    csa_carry = carry_q;
    pp        = '0;
    tsum      = '0;
    maj       = '0;
    for (int k = 0; k < STEP; k++) begin
      pp        = mplier_q[k] ? (mcand_q << k) : '0;
      tsum      = csa_sum ^ csa_carry ^ pp;
      maj       = (csa_sum & csa_carry) | (csa_sum & pp) | (csa_carry & pp);
      csa_sum   = tsum;
      csa_carry = maj << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sum_q    <= '0;
      carry_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= PW'(in_a);
            mplier_q <= in_b;
            sum_q    <= in_acc ? res_q : '0;
            carry_q  <= '0;
            cnt_q    <= '0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          sum_q    <= csa_sum;
          carry_q  <= csa_carry;
          mcand_q  <= mcand_q << STEP;
          mplier_q <= mplier_q >> STEP;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST) state <= RESOLVE;
        end
        RESOLVE: begin
          res_q <= sum_q + carry_q;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The result register doubles as the output, so out_p only moves in RESOLVE.
  assign out_p     = res_q;
  assign out_valid = (state == DONE);
  assign in_ready  = (state == IDLE);
  assign busy      = (state == ACCUM) || (state == RESOLVE);

endmodule

// File: tb/tb_csa_mult_seq.sv
// Bench for csa_mult_seq: an 8-bit/STEP=1 instance for directed cases and a 16-bit/STEP=4 instance for random MAC.
module tb_csa_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv8 = 0, ir8, acc8 = 0, ov8, or8 = 0, busy8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;

  logic        iv16 = 0, ir16, acc16 = 0, ov16, or16 = 0, busy16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;

  csa_mult_seq #(.WIDTH(8), .STEP(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_acc(acc8), .out_valid(ov8), .out_ready(or8), .out_p(p8), .busy(busy8));

  csa_mult_seq #(.WIDTH(16), .STEP(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_acc(acc16), .out_valid(ov16), .out_ready(or16), .out_p(p16), .busy(busy16));

  int checks = 0;
  int failures = 0;

  logic [15:0] q8[$];
  logic [31:0] q16[$];
  logic [15:0] r8  = 0;
  logic [31:0] r16 = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic acc);
    logic [15:0] e;
    iv8 = 1; a8 = a; b8 = b; acc8 = acc;
    tick();
    iv8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); acc8 = 1'($urandom);
    e = (acc ? r8 : 16'h0) + 16'(a) * 16'(b);
    r8 = e;
    q8.push_back(e);
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic acc);
    logic [31:0] e;
    iv16 = 1; a16 = a; b16 = b; acc16 = acc;
    tick();
    iv16 = 0; a16 = 16'($urandom); b16 = 16'($urandom);
    e = (acc ? r16 : 32'h0) + 32'(a) * 32'(b);
    r16 = e;
    q16.push_back(e);
  endtask

  task automatic wait8(output int edges, output bit to);
    edges = 0; to = 0;
    while (ov8 !== 1'b1 && !to) begin
      tick();
      edges++;
      if (edges > 100) to = 1;
    end
  endtask

  task automatic wait16(input bit rand_ready, output int edges, output bit to);
    edges = 0; to = 0;
    while (ov16 !== 1'b1 && !to) begin
      if (rand_ready) or16 = 1'($urandom);
      tick();
      edges++;
      if (edges > 100) to = 1;
    end
    or16 = 0;
  endtask

  task automatic hs8();
    or8 = 1; tick(); or8 = 0;
  endtask

  task automatic hs16();
    or16 = 1; tick(); or16 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    checks++;
    if (ir8 !== 1 || ov8 !== 0 || busy8 !== 0 || p8 !== 16'h0) begin
      failures++;
      $display("FAIL reset8: ir=%b ov=%b busy=%b p=%h, required 1 0 0 0000", ir8, ov8, busy8, p8);
    end
    checks++;
    if (ir16 !== 1 || ov16 !== 0 || busy16 !== 0 || p16 !== 32'h0) begin
      failures++;
      $display("FAIL reset16: ir=%b ov=%b busy=%b p=%h, required 1 0 0 0", ir16, ov16, busy16, p16);
    end
  endtask

  task automatic test_latency8();
    int edges; bit to; logic [15:0] e;
    issue8(8'hFF, 8'hFF, 1'b0);
    checks++;
    if (ir8 !== 0 || busy8 !== 1) begin
      failures++;
      $display("FAIL accept_state8: ir=%b busy=%b, required 0 1", ir8, busy8);
    end
    wait8(edges, to);
    e = q8.pop_front();
    checks++;
    if (to || edges != 9) begin
      failures++;
      $display("FAIL latency8: edges=%0d timeout=%0b, required 9", edges, to);
    end
    checks++;
    if (p8 !== e || p8 !== 16'hFE01) begin
      failures++;
      $display("FAIL ffxff8: p=%h, required %h", p8, e);
    end
    checks++;
    if (ir8 !== 0 || busy8 !== 0) begin
      failures++;
      $display("FAIL done_state8: ir=%b busy=%b, required 0 0", ir8, busy8);
    end
    hs8();
    checks++;
    if (ir8 !== 1 || ov8 !== 0) begin
      failures++;
      $display("FAIL handshake8: ir=%b ov=%b, required 1 0", ir8, ov8);
    end
  endtask

  task automatic test_patterns8();
    logic [7:0] ta[6] = '{8'd0,   8'd173, 8'd3, 8'd5, 8'd255, 8'd255};
    logic [7:0] tb[6] = '{8'd173, 8'd1,   8'd4, 8'd6, 8'd255, 8'd255};
    logic       tc[6] = '{1'b0,   1'b0,   1'b0, 1'b1, 1'b0,   1'b1};
    logic [15:0] want[6] = '{16'h0000, 16'h00AD, 16'h000C, 16'h002A, 16'hFE01, 16'hFC02};
    int edges; bit to; logic [15:0] e;
    for (int i = 0; i < 6; i++) begin
      issue8(ta[i], tb[i], tc[i]);
      wait8(edges, to);
      e = q8.pop_front();
      checks++;
      if (to || p8 !== e || p8 !== want[i]) begin
        failures++;
        $display("FAIL pattern8[%0d]: p=%h timeout=%0b, required %h", i, p8, to, want[i]);
      end
      hs8();
    end
  endtask

  task automatic test_backpressure8();
    int edges; bit to; logic [15:0] e;
    issue8(8'd77, 8'd201, 1'b0);
    wait8(edges, to);
    e = q8.pop_front();
    iv8 = 1; a8 = 8'd9; b8 = 8'd9;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (to || ov8 !== 1 || p8 !== e || ir8 !== 0) begin
        failures++;
        $display("FAIL stall8[%0d]: ov=%b p=%h ir=%b, required 1 %h 0", i, ov8, p8, ir8, e);
      end
      tick();
    end
    iv8 = 0;
    hs8();
    checks++;
    if (ir8 !== 1 || ov8 !== 0 || busy8 !== 0 || p8 !== e) begin
      failures++;
      $display("FAIL release8: ir=%b ov=%b busy=%b p=%h, required 1 0 0 %h", ir8, ov8, busy8, p8, e);
    end
  endtask

  task automatic test_reset_mid8();
    int edges; bit to; logic [15:0] e;
    issue8(8'd200, 8'd150, 1'b0);
    tick(); tick(); tick();
    rst = 1; tick(); rst = 0;
    void'(q8.pop_back());
    r8 = 0;
    checks++;
    if (ov8 !== 0 || busy8 !== 0 || ir8 !== 1 || p8 !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid8: ov=%b busy=%b ir=%b p=%h, required 0 0 1 0000", ov8, busy8, ir8, p8);
    end
    issue8(8'd2, 8'd3, 1'b1);
    wait8(edges, to);
    e = q8.pop_front();
    checks++;
    if (to || p8 !== e || p8 !== 16'h0006) begin
      failures++;
      $display("FAIL acc_after_reset8: p=%h timeout=%0b, required 0006", p8, to);
    end
    hs8();
    // Keep the 16-bit model in step: that instance saw the same reset.
    r16 = 0;
  endtask

  task automatic test_wide16();
    int edges; bit to; logic [31:0] e;
    issue16(16'hFFFF, 16'hFFFF, 1'b0);
    wait16(1'b0, edges, to);
    e = q16.pop_front();
    checks++;
    if (to || edges != 5) begin
      failures++;
      $display("FAIL latency16: edges=%0d timeout=%0b, required 5", edges, to);
    end
    checks++;
    if (p16 !== e || p16 !== 32'hFFFE0001) begin
      failures++;
      $display("FAIL ffffxffff16: p=%h, required FFFE0001", p16);
    end
    hs16();
  endtask

  task automatic test_random16();
    int edges; bit to; logic [31:0] e; int stall;
    for (int i = 0; i < 1000; i++) begin
      issue16(16'($urandom), 16'($urandom), 1'($urandom));
      wait16(1'b1, edges, to);
      e = q16.pop_front();
      checks++;
      if (to || p16 !== e) begin
        failures++;
        $display("FAIL random16[%0d]: p=%h timeout=%0b, required %h", i, p16, to, e);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) tick();
      if (i % 100 == 0) begin
        checks++;
        if (ov16 !== 1 || p16 !== e) begin
          failures++;
          $display("FAIL hold16[%0d]: ov=%b p=%h, required 1 %h", i, ov16, p16, e);
        end
      end
      hs16();
    end
  endtask

  initial begin
    test_reset();
    test_latency8();
    test_patterns8();
    test_backpressure8();
    test_reset_mid8();
    test_wide16();
    test_random16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
